// File: rtl/axi_pkg.sv
// AXI channel payload structs and arbiter state encodings.
// Shared by the round-robin arbiter and its picker.
package axi_pkg;

    localparam int AXI_ID_WIDTH   = 4;
    localparam int AXI_ADDR_WIDTH = 32;
    localparam int AXI_DATA_WIDTH = 32;
    localparam int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;

    typedef struct packed {
        logic [AXI_ID_WIDTH-1:0]   id;
        logic [AXI_ADDR_WIDTH-1:0] addr;
        logic [7:0]                len;
        logic [2:0]                size;
        logic [1:0]                burst;
    } axi_aw_t;

    typedef struct packed {
        logic [AXI_ID_WIDTH-1:0]   id;
        logic [AXI_ADDR_WIDTH-1:0] addr;
        logic [7:0]                len;
        logic [2:0]                size;
        logic [1:0]                burst;
    } axi_ar_t;

    typedef struct packed {
        logic [AXI_DATA_WIDTH-1:0] data;
        logic [AXI_STRB_WIDTH-1:0] strb;
        logic                      last;
    } axi_w_t;

    typedef struct packed {
        logic [AXI_ID_WIDTH-1:0] id;
        logic [1:0]              resp;
    } axi_b_t;

    typedef struct packed {
        logic [AXI_ID_WIDTH-1:0]   id;
        logic [AXI_DATA_WIDTH-1:0] data;
        logic [1:0]                resp;
        logic                      last;
    } axi_r_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_AW,
        W_DATA,
        W_RESP
    } arb_wr_state_e;

    typedef enum logic [1:0] {
        R_IDLE,
        R_AR,
        R_RESP
    } arb_rd_state_e;

endpackage

// File: rtl/axi_rr_arbiter_rr_pick.sv
// Cyclic first-requester picker: lowest index at or after ptr_i.
// Handles non-power-of-2 requester counts.
module rr_pick #(
    parameter  int N_MGR = 4,
    localparam int IDX_W = $clog2(N_MGR)
) (
    input  logic [N_MGR-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [IDX_W-1:0] gnt_idx_o,
    output logic             any_req_o
);

    logic             found;
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] idx;

    always_comb begin
        gnt_idx_o = '0;
        found     = 1'b0;
        sum       = '0;
        idx       = '0;
        for (int i = 0; i < N_MGR; i++) begin
            sum = {1'b0, ptr_i} + (IDX_W+1)'(i);
            if (sum >= (IDX_W+1)'(N_MGR)) begin
                sum = sum - (IDX_W+1)'(N_MGR);
            end
            idx = sum[IDX_W-1:0];
            if (!found && req_i[idx]) begin
                found     = 1'b1;
                gnt_idx_o = idx;
            end
        end
    end

    assign any_req_o = |req_i;

endmodule

// File: rtl/axi_rr_arbiter.sv
// N-to-1 AXI round-robin arbiter, independent write and read paths.
// Optional per-manager grant counters: AXI_RR_ARBITER_STATS_EN.
module axi_rr_arbiter
    import axi_pkg::*;
#(
    parameter int N_MGR = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  axi_aw_t          i_axi_s_aw      [N_MGR],
    input  logic [N_MGR-1:0] i_axi_s_awvalid,
    output logic [N_MGR-1:0] o_axi_s_awready,
    input  axi_w_t           i_axi_s_w       [N_MGR],
    input  logic [N_MGR-1:0] i_axi_s_wvalid,
    output logic [N_MGR-1:0] o_axi_s_wready,
    output axi_b_t           o_axi_s_b       [N_MGR],
    output logic [N_MGR-1:0] o_axi_s_bvalid,
    input  logic [N_MGR-1:0] i_axi_s_bready,
    input  axi_ar_t          i_axi_s_ar      [N_MGR],
    input  logic [N_MGR-1:0] i_axi_s_arvalid,
    output logic [N_MGR-1:0] o_axi_s_arready,
    output axi_r_t           o_axi_s_r       [N_MGR],
    output logic [N_MGR-1:0] o_axi_s_rvalid,
    input  logic [N_MGR-1:0] i_axi_s_rready,
    output axi_aw_t          o_axi_m_aw,
    output logic             o_axi_m_awvalid,
    input  logic             i_axi_m_awready,
    output axi_w_t           o_axi_m_w,
    output logic             o_axi_m_wvalid,
    input  logic             i_axi_m_wready,
    input  axi_b_t           i_axi_m_b,
    input  logic             i_axi_m_bvalid,
    output logic             o_axi_m_bready,
    output axi_ar_t          o_axi_m_ar,
    output logic             o_axi_m_arvalid,
    input  logic             i_axi_m_arready,
    input  axi_r_t           i_axi_m_r,
    input  logic             i_axi_m_rvalid,
    output logic             o_axi_m_rready
`ifdef AXI_RR_ARBITER_STATS_EN
    ,
    output logic [31:0]      o_wr_grant_cnt  [N_MGR],
    output logic [31:0]      o_rd_grant_cnt  [N_MGR]
`endif
);

    localparam int IDX_W = $clog2(N_MGR);

    arb_wr_state_e    wst_q, wst_d;
    arb_rd_state_e    rst_q, rst_d;
    logic [IDX_W-1:0] wgnt_q, wgnt_d, wptr_q, wptr_d;
    logic [IDX_W-1:0] rgnt_q, rgnt_d, rptr_q, rptr_d;
    logic [IDX_W-1:0] wpick, rpick;
    logic             wany, rany;
    logic             aw_hs, w_hs, b_hs, ar_hs, r_hs;

    function automatic logic [IDX_W-1:0] ptr_inc(input logic [IDX_W-1:0] p);
        return (p == IDX_W'(N_MGR-1)) ? '0 : p + 1'b1;
    endfunction

    rr_pick #(.N_MGR(N_MGR)) u_wr_pick (
        .req_i     (i_axi_s_awvalid),
        .ptr_i     (wptr_q),
        .gnt_idx_o (wpick),
        .any_req_o (wany)
    );

    rr_pick #(.N_MGR(N_MGR)) u_rd_pick (
        .req_i     (i_axi_s_arvalid),
        .ptr_i     (rptr_q),
        .gnt_idx_o (rpick),
        .any_req_o (rany)
    );

    assign aw_hs = (wst_q == W_AW) && i_axi_s_awvalid[wgnt_q] && i_axi_m_awready;
    assign w_hs  = (wst_q == W_DATA) && i_axi_s_wvalid[wgnt_q] && i_axi_m_wready;
    assign b_hs  = (wst_q == W_RESP) && i_axi_m_bvalid && i_axi_s_bready[wgnt_q];
    assign ar_hs = (rst_q == R_AR) && i_axi_s_arvalid[rgnt_q] && i_axi_m_arready;
    assign r_hs  = (rst_q == R_RESP) && i_axi_m_rvalid && i_axi_s_rready[rgnt_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wst_q  <= W_IDLE;
            wgnt_q <= '0;
            wptr_q <= '0;
            rst_q  <= R_IDLE;
            rgnt_q <= '0;
            rptr_q <= '0;
        end else begin
            wst_q  <= wst_d;
            wgnt_q <= wgnt_d;
            wptr_q <= wptr_d;
            rst_q  <= rst_d;
            rgnt_q <= rgnt_d;
            rptr_q <= rptr_d;
        end
    end

    always_comb begin
        wst_d           = wst_q;
        wgnt_d          = wgnt_q;
        wptr_d          = wptr_q;
        o_axi_m_aw      = '0;
        o_axi_m_awvalid = 1'b0;
        o_axi_s_awready = '0;
        o_axi_m_w       = '0;
        o_axi_m_wvalid  = 1'b0;
        o_axi_s_wready  = '0;
        o_axi_m_bready  = 1'b0;
        o_axi_s_bvalid  = '0;
        for (int i = 0; i < N_MGR; i++) o_axi_s_b[i] = '0;
        unique case (wst_q)
            W_IDLE: begin
                if (wany) begin
                    wgnt_d = wpick;
                    wst_d  = W_AW;
                end
            end
            W_AW: begin
                o_axi_m_aw              = i_axi_s_aw[wgnt_q];
                o_axi_m_awvalid         = i_axi_s_awvalid[wgnt_q];
                o_axi_s_awready[wgnt_q] = i_axi_m_awready;
                if (aw_hs) begin
                    wst_d  = W_DATA;
                    wptr_d = ptr_inc(wgnt_q);
                end
            end
            W_DATA: begin
                o_axi_m_w              = i_axi_s_w[wgnt_q];
                o_axi_m_wvalid         = i_axi_s_wvalid[wgnt_q];
                o_axi_s_wready[wgnt_q] = i_axi_m_wready;
                if (w_hs && i_axi_s_w[wgnt_q].last) wst_d = W_RESP;
            end
            W_RESP: begin
                o_axi_m_bready         = i_axi_s_bready[wgnt_q];
                o_axi_s_bvalid[wgnt_q] = i_axi_m_bvalid;
                for (int i = 0; i < N_MGR; i++) o_axi_s_b[i] = i_axi_m_b;
                if (b_hs) wst_d = W_IDLE;
            end
            default: wst_d = W_IDLE;
        endcase
    end

    always_comb begin
        rst_d           = rst_q;
        rgnt_d          = rgnt_q;
        rptr_d          = rptr_q;
        o_axi_m_ar      = '0;
        o_axi_m_arvalid = 1'b0;
        o_axi_s_arready = '0;
        o_axi_m_rready  = 1'b0;
        o_axi_s_rvalid  = '0;
        for (int i = 0; i < N_MGR; i++) o_axi_s_r[i] = '0;
        unique case (rst_q)
            R_IDLE: begin
                if (rany) begin
                    rgnt_d = rpick;
                    rst_d  = R_AR;
                end
            end
            R_AR: begin
                o_axi_m_ar              = i_axi_s_ar[rgnt_q];
                o_axi_m_arvalid         = i_axi_s_arvalid[rgnt_q];
                o_axi_s_arready[rgnt_q] = i_axi_m_arready;
                if (ar_hs) begin
                    rst_d  = R_RESP;
                    rptr_d = ptr_inc(rgnt_q);
                end
            end
            R_RESP: begin
                o_axi_m_rready         = i_axi_s_rready[rgnt_q];
                o_axi_s_rvalid[rgnt_q] = i_axi_m_rvalid;
                for (int i = 0; i < N_MGR; i++) o_axi_s_r[i] = i_axi_m_r;
                if (r_hs && i_axi_m_r.last) rst_d = R_IDLE;
            end
            default: rst_d = R_IDLE;
        endcase
    end

`ifdef AXI_RR_ARBITER_STATS_EN
    logic [31:0] wr_cnt_q [N_MGR];
    logic [31:0] rd_cnt_q [N_MGR];

    // Counters wrap naturally at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_MGR; i++) begin
                wr_cnt_q[i] <= '0;
                rd_cnt_q[i] <= '0;
            end
        end else begin
            if (aw_hs) wr_cnt_q[wgnt_q] <= wr_cnt_q[wgnt_q] + 32'd1;
            if (ar_hs) rd_cnt_q[rgnt_q] <= rd_cnt_q[rgnt_q] + 32'd1;
        end
    end

    assign o_wr_grant_cnt = wr_cnt_q;
    assign o_rd_grant_cnt = rd_cnt_q;
`endif

endmodule

// File: tb/tb_axi_rr_arbiter.sv
// Directed self-checking bench for axi_rr_arbiter (N_MGR = 4).
// Build with AXI_RR_ARBITER_STATS_EN to also cover the grant counters.
module tb_axi_rr_arbiter;
    import axi_pkg::*;

    localparam int N = 4;

    logic clk, rst_n;
    axi_aw_t s_aw [N];
    logic [N-1:0] s_awvalid, s_awready;
    axi_w_t s_w [N];
    logic [N-1:0] s_wvalid, s_wready;
    axi_b_t s_b [N];
    logic [N-1:0] s_bvalid, s_bready;
    axi_ar_t s_ar [N];
    logic [N-1:0] s_arvalid, s_arready;
    axi_r_t s_r [N];
    logic [N-1:0] s_rvalid, s_rready;
    axi_aw_t m_aw;
    logic m_awvalid, m_awready;
    axi_w_t m_w;
    logic m_wvalid, m_wready;
    axi_b_t m_b;
    logic m_bvalid, m_bready;
    axi_ar_t m_ar;
    logic m_arvalid, m_arready;
    axi_r_t m_r;
    logic m_rvalid, m_rready;
`ifdef AXI_RR_ARBITER_STATS_EN
    logic [31:0] wr_cnt [N];
    logic [31:0] rd_cnt [N];
`endif

    int errors = 0;
    int checks = 0;

    logic         obs_to;
    logic [N-1:0] obs_awrdy, obs_wrdy, obs_bv, obs_arrdy, obs_rv;
    logic [31:0]  obs_addr, obs_wdata, obs_araddr, obs_rdata;
    logic         obs_wv_early, obs_wv, obs_mbready;
    logic [3:0]   obs_bid, obs_arid;

    axi_rr_arbiter #(.N_MGR(N)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_axi_s_aw      (s_aw),
        .i_axi_s_awvalid (s_awvalid),
        .o_axi_s_awready (s_awready),
        .i_axi_s_w       (s_w),
        .i_axi_s_wvalid  (s_wvalid),
        .o_axi_s_wready  (s_wready),
        .o_axi_s_b       (s_b),
        .o_axi_s_bvalid  (s_bvalid),
        .i_axi_s_bready  (s_bready),
        .i_axi_s_ar      (s_ar),
        .i_axi_s_arvalid (s_arvalid),
        .o_axi_s_arready (s_arready),
        .o_axi_s_r       (s_r),
        .o_axi_s_rvalid  (s_rvalid),
        .i_axi_s_rready  (s_rready),
        .o_axi_m_aw      (m_aw),
        .o_axi_m_awvalid (m_awvalid),
        .i_axi_m_awready (m_awready),
        .o_axi_m_w       (m_w),
        .o_axi_m_wvalid  (m_wvalid),
        .i_axi_m_wready  (m_wready),
        .i_axi_m_b       (m_b),
        .i_axi_m_bvalid  (m_bvalid),
        .o_axi_m_bready  (m_bready),
        .o_axi_m_ar      (m_ar),
        .o_axi_m_arvalid (m_arvalid),
        .i_axi_m_arready (m_arready),
        .i_axi_m_r       (m_r),
        .i_axi_m_rvalid  (m_rvalid),
        .o_axi_m_rready  (m_rready)
`ifdef AXI_RR_ARBITER_STATS_EN
        ,
        .o_wr_grant_cnt  (wr_cnt),
        .o_rd_grant_cnt  (rd_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int oh2idx(input logic [N-1:0] v);
        int r = 0;
        for (int i = 0; i < N; i++) if (v[i]) r = i;
        return r;
    endfunction

    function automatic logic [31:0] wdata_of(input int i);
        return 32'h0000_A5A5 | ((32'(i) ^ 32'd2) << 16);
    endfunction

    function automatic logic [31:0] araddr_of(input int i);
        return 32'h8000_0000 | (32'(i) << 8);
    endfunction

    task automatic clear_inputs();
        for (int i = 0; i < N; i++) begin
            s_aw[i] = '0;
            s_w[i]  = '0;
            s_ar[i] = '0;
        end
        s_awvalid = '0;
        s_wvalid  = '0;
        s_arvalid = '0;
        s_bready  = '1;
        s_rready  = '1;
        m_awready = 1'b1;
        m_wready  = 1'b1;
        m_arready = 1'b1;
        m_b       = '0;
        m_bvalid  = 1'b0;
        m_r       = '0;
        m_rvalid  = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Drive one write from the managers in mask; the granted one completes.
    task automatic wr_txn(input logic [N-1:0] mask);
        int g;
        int n;
        obs_to = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (mask[i]) begin
                s_awvalid[i] = 1'b1;
                s_aw[i] = '{id: 4'(i), addr: 32'(i) << 12,
                            len: 8'd0, size: 3'd2, burst: 2'd1};
                s_wvalid[i] = 1'b1;
                s_w[i] = '{data: wdata_of(i), strb: 4'hF, last: 1'b1};
            end
        end
        m_awready = 1'b1;
        m_wready  = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!m_awvalid && n < 20);
        if (!m_awvalid) begin
            obs_to = 1'b1;
            s_awvalid = '0;
            s_wvalid  = '0;
            return;
        end
        obs_awrdy    = s_awready;
        obs_addr     = m_aw.addr;
        obs_wv_early = m_wvalid;
        g = oh2idx(obs_awrdy);
        @(negedge clk);
        s_awvalid[g] = 1'b0;
        #1;
        obs_wv    = m_wvalid;
        obs_wdata = m_w.data;
        obs_wrdy  = s_wready;
        @(negedge clk);
        s_wvalid[g] = 1'b0;
        m_bvalid = 1'b1;
        m_b = '{id: 4'(g), resp: 2'b00};
        #1;
        obs_bv      = s_bvalid;
        obs_bid     = s_b[g].id;
        obs_mbready = m_bready;
        @(negedge clk);
        m_bvalid  = 1'b0;
        s_awvalid = '0;
        s_wvalid  = '0;
    endtask

    // Drive one read from the managers in mask; the granted one completes.
    task automatic rd_txn(input logic [N-1:0] mask);
        int g;
        int n;
        obs_to = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (mask[i]) begin
                s_arvalid[i] = 1'b1;
                s_ar[i] = '{id: 4'(i), addr: araddr_of(i),
                            len: 8'd0, size: 3'd2, burst: 2'd1};
            end
        end
        m_arready = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!m_arvalid && n < 20);
        if (!m_arvalid) begin
            obs_to = 1'b1;
            s_arvalid = '0;
            return;
        end
        obs_arrdy  = s_arready;
        obs_araddr = m_ar.addr;
        obs_arid   = m_ar.id;
        g = oh2idx(obs_arrdy);
        @(negedge clk);
        s_arvalid[g] = 1'b0;
        m_rvalid = 1'b1;
        m_r = '{id: obs_arid, data: 32'hD000_0000 | 32'(g),
                resp: 2'b00, last: 1'b1};
        #1;
        obs_rv    = s_rvalid;
        obs_rdata = s_r[g].data;
        @(negedge clk);
        m_rvalid  = 1'b0;
        s_arvalid = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        s_awvalid = 4'b1111;
        s_arvalid = 4'b1111;
        m_bvalid  = 1'b1;
        m_rvalid  = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready} !== 5'b0) begin
            errors++;
            $display("FAIL reset_m_ctrl: got %b want 00000",
                     {m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready});
        end
        checks++;
        if ({s_awready, s_wready, s_arready, s_bvalid, s_rvalid} !== 20'b0) begin
            errors++;
            $display("FAIL reset_s_ctrl: got %h want 0",
                     {s_awready, s_wready, s_arready, s_bvalid, s_rvalid});
        end
        checks++;
        if (m_aw !== '0 || m_ar !== '0 || s_b[0] !== '0 || s_r[0] !== '0) begin
            errors++;
            $display("FAIL reset_payload: got aw=%h ar=%h want 0", m_aw, m_ar);
        end
        clear_inputs();
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_write();
        wr_txn(4'b0100);
        checks++;
        if (obs_to !== 1'b0) begin
            errors++;
            $display("FAIL sw_timeout: got %b want 0", obs_to);
        end
        checks++;
        if (obs_awrdy !== 4'b0100 || obs_addr !== 32'h2000) begin
            errors++;
            $display("FAIL sw_aw: got rdy=%b addr=%h want 0100 2000",
                     obs_awrdy, obs_addr);
        end
        checks++;
        if (obs_wv_early !== 1'b0) begin
            errors++;
            $display("FAIL sw_w_before_aw: got %b want 0", obs_wv_early);
        end
        checks++;
        if (obs_wv !== 1'b1 || obs_wdata !== 32'hA5A5 || obs_wrdy !== 4'b0100) begin
            errors++;
            $display("FAIL sw_w: got v=%b d=%h rdy=%b want 1 a5a5 0100",
                     obs_wv, obs_wdata, obs_wrdy);
        end
        checks++;
        if (obs_bv !== 4'b0100 || obs_bid !== 4'd2 || obs_mbready !== 1'b1) begin
            errors++;
            $display("FAIL sw_b: got bv=%b id=%0d brdy=%b want 0100 2 1",
                     obs_bv, obs_bid, obs_mbready);
        end
    endtask

    task automatic test_wr_ptr();
        wr_txn(4'b1001);
        checks++;
        if (obs_to !== 1'b0 || obs_awrdy !== 4'b1000 || obs_bv !== 4'b1000) begin
            errors++;
            $display("FAIL wr_ptr3: got rdy=%b bv=%b want 1000 1000",
                     obs_awrdy, obs_bv);
        end
        wr_txn(4'b1001);
        checks++;
        if (obs_to !== 1'b0 || obs_awrdy !== 4'b0001 || obs_bv !== 4'b0001) begin
            errors++;
            $display("FAIL wr_ptr_wrap: got rdy=%b bv=%b want 0001 0001",
                     obs_awrdy, obs_bv);
        end
    endtask

    task automatic test_read_fairness();
        int g;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            g = k % N;
            rd_txn(4'b1111);
            checks++;
            if (obs_to !== 1'b0 || obs_arrdy !== 4'(1 << g) ||
                obs_araddr !== araddr_of(g) || obs_arid !== 4'(g)) begin
                errors++;
                $display("FAIL rr_grant%0d: got rdy=%b addr=%h want %b %h",
                         k, obs_arrdy, obs_araddr, 4'(1 << g), araddr_of(g));
            end
            checks++;
            if (obs_rv !== 4'(1 << g) || obs_rdata !== (32'hD000_0000 | 32'(g))) begin
                errors++;
                $display("FAIL rr_resp%0d: got rv=%b d=%h want %b %h",
                         k, obs_rv, obs_rdata, 4'(1 << g), 32'hD000_0000 | 32'(g));
            end
        end
    endtask

    task automatic test_concurrent();
        s_awvalid[1] = 1'b1;
        s_aw[1] = '{id: 4'd1, addr: 32'h0000_1000, len: 8'd0, size: 3'd2, burst: 2'd1};
        s_wvalid[1] = 1'b1;
        s_w[1] = '{data: 32'h1111_2222, strb: 4'hF, last: 1'b1};
        s_arvalid[3] = 1'b1;
        s_ar[3] = '{id: 4'd3, addr: 32'h0000_3000, len: 8'd0, size: 3'd2, burst: 2'd1};
        @(negedge clk);
        checks++;
        if (m_awvalid !== 1'b1 || m_arvalid !== 1'b1 ||
            s_awready !== 4'b0010 || s_arready !== 4'b1000 ||
            m_aw.addr !== 32'h1000 || m_ar.addr !== 32'h3000) begin
            errors++;
            $display("FAIL cc_addr: got aw=%b/%b ar=%b/%b want 1/0010 1/1000",
                     m_awvalid, s_awready, m_arvalid, s_arready);
        end
        @(negedge clk);
        s_awvalid[1] = 1'b0;
        s_arvalid[3] = 1'b0;
        m_rvalid = 1'b1;
        m_r = '{id: 4'd3, data: 32'hCAFE_0003, resp: 2'b00, last: 1'b1};
        #1;
        checks++;
        if (m_wvalid !== 1'b1 || s_wready !== 4'b0010 ||
            s_rvalid !== 4'b1000 || s_r[3].data !== 32'hCAFE_0003 ||
            m_w.data !== 32'h1111_2222) begin
            errors++;
            $display("FAIL cc_data: got wv=%b wrdy=%b rv=%b want 1 0010 1000",
                     m_wvalid, s_wready, s_rvalid);
        end
        @(negedge clk);
        s_wvalid[1] = 1'b0;
        m_rvalid = 1'b0;
        m_bvalid = 1'b1;
        m_b = '{id: 4'd1, resp: 2'b00};
        #1;
        checks++;
        if (s_bvalid !== 4'b0010 || s_rvalid !== 4'b0000) begin
            errors++;
            $display("FAIL cc_resp: got bv=%b rv=%b want 0010 0000",
                     s_bvalid, s_rvalid);
        end
        @(negedge clk);
        m_bvalid = 1'b0;
    endtask

    task automatic test_aw_stall();
        int bad = 0;
        m_awready = 1'b0;
        s_awvalid[0] = 1'b1;
        s_aw[0] = '{id: 4'd0, addr: 32'h0000_0040, len: 8'd0, size: 3'd2, burst: 2'd1};
        s_wvalid[0] = 1'b1;
        s_w[0] = '{data: 32'h0BAD_F00D, strb: 4'hF, last: 1'b1};
        @(negedge clk);
        for (int c = 0; c < 10; c++) begin
            if (m_awvalid !== 1'b1 || m_wvalid !== 1'b0 ||
                s_awready !== 4'b0000 || s_wready !== 4'b0000) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL stall_hold: got %0d bad cycles want 0", bad);
        end
        m_awready = 1'b1;
        @(negedge clk);
        s_awvalid[0] = 1'b0;
        #1;
        checks++;
        if (m_wvalid !== 1'b1 || m_w.data !== 32'h0BAD_F00D) begin
            errors++;
            $display("FAIL stall_release: got wv=%b d=%h want 1 0badf00d",
                     m_wvalid, m_w.data);
        end
        @(negedge clk);
        s_wvalid[0] = 1'b0;
        m_bvalid = 1'b1;
        @(negedge clk);
        m_bvalid = 1'b0;
    endtask

    task automatic test_reset_mid_write();
        m_wready = 1'b0;
        s_awvalid[0] = 1'b1;
        s_aw[0] = '{id: 4'd0, addr: 32'h0000_0080, len: 8'd0, size: 3'd2, burst: 2'd1};
        s_wvalid[0] = 1'b1;
        s_w[0] = '{data: 32'h1234_5678, strb: 4'hF, last: 1'b1};
        @(negedge clk);
        @(negedge clk);
        s_awvalid[0] = 1'b0;
        #1;
        checks++;
        if (m_wvalid !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre: got wv=%b want 1", m_wvalid);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({m_awvalid, m_wvalid, m_bready, s_wready, s_awready, s_bvalid} !== 15'b0 ||
            m_w !== '0) begin
            errors++;
            $display("FAIL rst_async: got %b want 0",
                     {m_awvalid, m_wvalid, m_bready, s_wready, s_awready, s_bvalid});
        end
        @(negedge clk);
        clear_inputs();
        rst_n = 1'b1;
        wr_txn(4'b0001);
        checks++;
        if (obs_to !== 1'b0 || obs_awrdy !== 4'b0001 || obs_wdata !== wdata_of(0) ||
            obs_bv !== 4'b0001) begin
            errors++;
            $display("FAIL rst_after: got rdy=%b d=%h bv=%b want 0001 %h 0001",
                     obs_awrdy, obs_wdata, obs_bv, wdata_of(0));
        end
    endtask

`ifdef AXI_RR_ARBITER_STATS_EN
    task automatic test_stats();
        do_reset();
        checks++;
        if (wr_cnt[0] !== 32'd0 || rd_cnt[0] !== 32'd0) begin
            errors++;
            $display("FAIL stats_reset: got %0d %0d want 0 0", wr_cnt[0], rd_cnt[0]);
        end
        for (int k = 0; k < 16; k++) rd_txn(4'b0011);
        checks++;
        if (rd_cnt[0] !== 32'd8 || rd_cnt[1] !== 32'd8 ||
            rd_cnt[2] !== 32'd0 || rd_cnt[3] !== 32'd0) begin
            errors++;
            $display("FAIL stats_rd: got %0d %0d %0d %0d want 8 8 0 0",
                     rd_cnt[0], rd_cnt[1], rd_cnt[2], rd_cnt[3]);
        end
        wr_txn(4'b0100);
        checks++;
        if (wr_cnt[2] !== 32'd1 || wr_cnt[0] !== 32'd0) begin
            errors++;
            $display("FAIL stats_wr: got %0d %0d want 1 0", wr_cnt[2], wr_cnt[0]);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_write();
        test_wr_ptr();
        test_read_fairness();
        test_concurrent();
        test_aw_stall();
        test_reset_mid_write();
`ifdef AXI_RR_ARBITER_STATS_EN
        test_stats();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axi_rr_arbiter.md
Name: axi_rr_arbiter

Overview:
- N-to-1 AXI arbiter sharing one subordinate port between N simple CPU managers; each manager issues single-beat (len 0), single-outstanding transactions.
- Independent round-robin arbitration for the write path (AW→W→B) and the read path (AR→R).
- Sits between the CPU manager ports and the shared memory/interconnect subordinate; uses `axi_pkg` channel structs unchanged.

Parameters:
- N_MGR, 4, number of manager ports (2..16).
- IDX_W, $clog2(N_MGR), grant index width (derived, not overridden).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- i_axi_s_aw[N_MGR]  in  axi_aw_t  per-manager AW payload
- i_axi_s_awvalid / o_axi_s_awready  in/out  N_MGR  per-manager AW handshake
- i_axi_s_w[N_MGR]  in  axi_w_t  per-manager W payload
- i_axi_s_wvalid / o_axi_s_wready  in/out  N_MGR
- o_axi_s_b[N_MGR]  out  axi_b_t  B payload (broadcast)
- o_axi_s_bvalid / i_axi_s_bready  out/in  N_MGR
- i_axi_s_ar[N_MGR]  in  axi_ar_t
- i_axi_s_arvalid / o_axi_s_arready  in/out  N_MGR
- o_axi_s_r[N_MGR]  out  axi_r_t  (broadcast)
- o_axi_s_rvalid / i_axi_s_rready  out/in  N_MGR
- o_axi_m_aw/awvalid, i_axi_m_awready; o_axi_m_w/wvalid, i_axi_m_wready; i_axi_m_b/bvalid, o_axi_m_bready; o_axi_m_ar/arvalid, i_axi_m_arready; i_axi_m_r/rvalid, o_axi_m_rready: subordinate-side single AXI port, types as above.

Behaviour:
- Reset: all valid/ready outputs 0, payload outputs '0, both FSMs IDLE, both RR pointers 0. Reset mid-transaction abandons it; no replay.
- Write FSM: W_IDLE → W_AW → W_DATA → W_RESP → W_IDLE.
  - W_IDLE: if any awvalid, grant the first requester at or after wr_ptr (cyclic); latch wgnt; next W_AW. One bubble cycle, no grant-cycle output.
  - W_AW: o_axi_m_aw = i_axi_s_aw[wgnt]; o_axi_m_awvalid = awvalid[wgnt]; o_axi_s_awready[wgnt] = i_axi_m_awready (combinational). On handshake → W_DATA; wr_ptr ← wgnt+1 mod N_MGR.
  - W_DATA: same pass-through for W, granted manager only; other managers' wready = 0. On handshake with last=1 → W_RESP. W arriving before AW is never accepted.
  - W_RESP: o_axi_m_bready = bready[wgnt]; bvalid routed only to wgnt; B payload broadcast. On handshake → W_IDLE.
- Read FSM: R_IDLE → R_AR → R_RESP → R_IDLE, same rules on the AR and R channels, with rd_ptr and rgnt. R_RESP exits on rvalid&rready&r.last.
- Read and write FSMs are fully independent; both may be active in the same cycle.
- Non-granted managers always see ready = 0 and response valid = 0.
- Responses are routed by latched grant, not by ID; the ID field is passed through unchanged.
- Fairness: with all N_MGR requesting continuously, grants occur in order k, k+1, …, each manager once per N_MGR transactions.
- Pointer wrap: N_MGR-1 → 0. Non-power-of-2 N_MGR is supported.
- A manager deasserting valid before handshake (protocol violation) stalls in the current state; no timeout.

Optional Feature:
- AXI_RR_ARBITER_STATS_EN.
  - Defined: adds outputs o_wr_grant_cnt[N_MGR] and o_rd_grant_cnt[N_MGR], 32 bits each. A manager's counter increments on its AW (resp. AR) handshake, wraps at 2^32, and is reset to 0.
  - Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- `axi_pkg` already supplies the channel structs and AXI_*_WIDTH constants.
- Add to `axi_pkg`: `arb_wr_state_e` and `arb_rd_state_e` enums.
- Sub-module `rr_pick` (combinational): inputs req[N_MGR] and ptr, outputs gnt_idx and any_req. Instantiated twice.

Test Plan:
- Single write, manager 2, addr 0x2000, data 0xA5A5: subordinate sees AW then W, B reaches only manager 2 → wr_ptr = 3.
- All 4 managers assert arvalid at once from reset: AR grants in order 0,1,2,3,0. Each R response arrives only at the granted manager.
- Concurrent write by manager 1 and read by manager 3: both subordinate channels active in the same cycle, no cross-routing.
- Subordinate holds awready = 0 for 10 cycles: manager's awvalid stays held, no W forwarded, FSM stays in W_AW.
- rst_n asserted in W_DATA: all outputs 0 asynchronously; after release, a new write from manager 0 completes normally.
- With AXI_RR_ARBITER_STATS_EN and 8 reads each from managers 0 and 1 → o_rd_grant_cnt = {8,8,0,0}.
